// File: rtl/led_matrix_pkg.sv
// rtl/led_matrix_pkg.sv - shared constants and scan-state type for the LED matrix scanner
package led_matrix_pkg;
  localparam int MAX_DIM      = 16;
  localparam int BRIGHT_W     = 4;
  localparam int SCAN_COL_W   = 5;
  localparam int SCAN_DWELL_W = 16;

  typedef struct packed {
    logic [SCAN_COL_W-1:0]   col;
    logic [SCAN_DWELL_W-1:0] dwell;
  } scan_state_t;
endpackage

// File: rtl/led_col_decoder.sv
// rtl/led_col_decoder.sv - parametrised one-hot column decoder with enable
module led_col_decoder #(
  parameter int N     = 8,
  parameter int SEL_W = 3
) (
  input  logic [SEL_W-1:0] sel_i,
  input  logic             en_i,
  output logic [N-1:0]     onehot_o
);

  always_comb begin
    onehot_o = '0;
    for (int i = 0; i < N; i++) begin
      onehot_o[i] = en_i && (sel_i == SEL_W'(i));
    end
  end

endmodule

// File: rtl/led_matrix_scanner.sv
// rtl/led_matrix_scanner.sv - column-scan LED matrix driver with tear-free shadow frame buffer
// Optional PWM dimming is compiled in with LED_MATRIX_DIMMING_EN.
module led_matrix_scanner
  import led_matrix_pkg::*;
#(
  parameter int ROWS  = 5,
  parameter int COLS  = 5,
  parameter int DWELL = 64,
  parameter int BLANK = 4
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      ena,
  input  logic [ROWS*COLS-1:0]      frame_in,
  input  logic                      frame_valid,
  output logic                      frame_ready,
  input  logic [BRIGHT_W-1:0]       brightness,
  output logic [ROWS-1:0]           rows,
  output logic [COLS-1:0]           cols,
  output logic [$clog2(COLS):0]     col_idx,
  output logic                      frame_start
);

  localparam int N   = ROWS * COLS;
  localparam int CIW = $clog2(COLS) + 1;
  localparam logic [SCAN_COL_W-1:0]   COL_LAST   = SCAN_COL_W'(COLS - 1);
  localparam logic [SCAN_DWELL_W-1:0] DWELL_LAST = SCAN_DWELL_W'(DWELL - 1);
  localparam logic [SCAN_DWELL_W-1:0] BLANK_V    = SCAN_DWELL_W'(BLANK);

  initial begin
    if (ROWS < 1 || ROWS > MAX_DIM) $error("ROWS out of range 1..16");
    if (COLS < 1 || COLS > MAX_DIM) $error("COLS out of range 1..16");
    if (BLANK >= DWELL) $error("BLANK must be less than DWELL");
`ifdef LED_MATRIX_DIMMING_EN
    if (DWELL % MAX_DIM != 0) $error("DWELL must be a multiple of 16 with dimming");
`endif
  end

  scan_state_t       scan_q, scan_d;
  logic [N-1:0]      act_q, act_d;
  logic [N-1:0]      shd_q, shd_d;
  logic              pend_q, pend_d;
  logic [ROWS-1:0]   rows_q, rows_d;
  logic [COLS-1:0]   cols_q, cols_d;
  logic [CIW-1:0]    col_idx_q, col_idx_d;
  logic              frame_start_q, frame_start_d;
  logic              frame_end, pwm_ok, lit;
  logic [ROWS-1:0]   row_sel;

`ifdef LED_MATRIX_DIMMING_EN
  assign pwm_ok = scan_q.dwell[3:0] < brightness;
`else
  logic unused_brightness;
  assign unused_brightness = ^brightness;
  assign pwm_ok = 1'b1;
`endif

  assign frame_end = (scan_q.col == COL_LAST) && (scan_q.dwell == DWELL_LAST);
  assign lit       = ena && (scan_q.dwell >= BLANK_V) && pwm_ok;

  always_comb begin
    scan_d = scan_q;
    act_d  = act_q;
    shd_d  = shd_q;
    pend_d = pend_q;

    if (!ena) begin
      scan_d = '0;
    end else if (scan_q.dwell == DWELL_LAST) begin
      scan_d.dwell = '0;
      scan_d.col   = (scan_q.col == COL_LAST) ? '0 : scan_q.col + 1'b1;
    end else begin
      scan_d.dwell = scan_q.dwell + 1'b1;
    end

    // Swap only at a frame boundary (or any time the display is idle) so the image never tears.
    if (pend_q && (frame_end || !ena)) begin
      act_d  = shd_q;
      pend_d = 1'b0;
    end else if (frame_valid && !pend_q) begin
      shd_d  = frame_in;
      pend_d = 1'b1;
    end
  end

  always_comb begin
    row_sel = '0;
    for (int r = 0; r < ROWS; r++) begin
      for (int cc = 0; cc < COLS; cc++) begin
        if (scan_q.col == SCAN_COL_W'(cc)) row_sel[r] = act_q[r*COLS + cc];
      end
    end
    rows_d        = lit ? row_sel : '0;
    col_idx_d     = scan_q.col[CIW-1:0];
    frame_start_d = ena && (scan_q.col == '0) && (scan_q.dwell == '0);
  end

  led_col_decoder #(
    .N     (COLS),
    .SEL_W (SCAN_COL_W)
  ) u_col_decoder (
    .sel_i    (scan_q.col),
    .en_i     (lit),
    .onehot_o (cols_d)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      scan_q        <= '0;
      act_q         <= '0;
      shd_q         <= '0;
      pend_q        <= 1'b0;
      rows_q        <= '0;
      cols_q        <= '0;
      col_idx_q     <= '0;
      frame_start_q <= 1'b0;
    end else begin
      scan_q        <= scan_d;
      act_q         <= act_d;
      shd_q         <= shd_d;
      pend_q        <= pend_d;
      rows_q        <= rows_d;
      cols_q        <= cols_d;
      col_idx_q     <= col_idx_d;
      frame_start_q <= frame_start_d;
    end
  end

  assign frame_ready = !pend_q;
  assign rows        = rows_q;
  assign cols        = cols_q;
  assign col_idx     = col_idx_q;
  assign frame_start = frame_start_q;

endmodule
